uart_cmd_ctrl: RTL



---
 rtl/uart_cmd_ctrl.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: command sequencer between the UART receive path and a
// memory port. It takes host frames {opcode, addr, data}, runs the memory
// write or read, and hands a response frame to the UART transmitter.
// A one-deep pending buffer holds a frame that arrives while a command is
// still in progress.
// Optional feature: define CMD_TIMEOUT_EN to abandon a memory request after
// TIMEOUT cycles without an ack. The design then answers with error code 2.
module uart_cmd_ctrl #(
  parameter int OPCDBYTE = 2,
  parameter int ADDRBYTE = 2,
  parameter int DATABYTE = 4,
  parameter int TIMEOUT  = 1024,
  localparam int FW      = 8 * (OPCDBYTE + ADDRBYTE + DATABYTE)
) (
  input  logic                    iCLOCK,
  input  logic                    iRESET,
  input  logic                    iRX_DONE,
  input  logic [FW-1:0]           iRX_FDATA,
  output logic                    oMEM_REQ,
  output logic                    oMEM_WE,
  output logic [8*ADDRBYTE-1:0]   oMEM_ADDR,
  output logic [8*DATABYTE-1:0]   oMEM_WDATA,
  input  logic                    iMEM_ACK,
  input  logic [8*DATABYTE-1:0]   iMEM_RDATA,
  output logic                    oTX_START,
  output logic [FW-1:0]           oTX_FDATA,
  input  logic                    iTX_DONE,
  output logic                    oBUSY,
  output logic                    oOVERRUN
);

  localparam int OW = 8 * OPCDBYTE;
  localparam int AW = 8 * ADDRBYTE;
  localparam int DW = 8 * DATABYTE;

  // Opcode values and response markers, zero-extended to the opcode field.
  localparam logic [OW-1:0] OPC_WRITE  = OW'(16'h0001);
  localparam logic [OW-1:0] OPC_READ   = OW'(16'h0002);
  localparam logic [OW-1:0] OPC_PING   = OW'(16'h0003);
  localparam logic [OW-1:0] RESP_OK    = OW'(16'h8000);
  localparam logic [OW-1:0] RESP_ERR   = OW'(16'hEEEE);
  localparam logic [DW-1:0] ERR_ILLEGAL = DW'(32'h0000_0001);

  // A parameter set outside the legal range stops elaboration.
  if (OPCDBYTE < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("uart_cmd_ctrl: OPCDBYTE must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_MEM     = 3'd2,
    ST_RESP    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_t;

  state_t          state_r, state_next;
  logic [FW-1:0]   cmd_r, cmd_next;
  logic            pend_full_r, pend_full_next;
  logic [FW-1:0]   pend_data_r, pend_data_next;
  logic            overrun_r, overrun_next;
  logic            mem_req_r, mem_req_next;
  logic            mem_we_r, mem_we_next;
  logic [AW-1:0]   mem_addr_r, mem_addr_next;
  logic [DW-1:0]   mem_wdata_r, mem_wdata_next;
  logic            tx_start_r, tx_start_next;
  logic [FW-1:0]   tx_fdata_r, tx_fdata_next;
  logic            busy_r;

  // Fields of the latched command, sliced MSB-first.
  logic [OW-1:0]   opc_s;
  logic [AW-1:0]   addr_s;
  logic [DW-1:0]   data_s;
  logic            is_mem_op_s;
  logic            is_legal_s;

  assign opc_s       = cmd_r[FW-1 -: OW];
  assign addr_s      = cmd_r[DW +: AW];
  assign data_s      = cmd_r[DW-1:0];
  assign is_mem_op_s = (opc_s == OPC_WRITE) || (opc_s == OPC_READ);
  assign is_legal_s  = is_mem_op_s || (opc_s == OPC_PING);

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] ERR_TIMEOUT = DW'(32'h0000_0002);
  logic [TW-1:0]   tmo_cnt_r, tmo_cnt_next;
  logic            tmo_hit_s;

  assign tmo_hit_s = (tmo_cnt_r == TW'(TIMEOUT - 1));

  // Memory ack watchdog: counts the cycles spent waiting in MEM.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      tmo_cnt_r <= {TW{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_next;
    end
  end
`endif

  // Next-state and next-output logic for the command sequencer and pending buffer.
  always_comb begin
    state_next     = state_r;
    cmd_next       = cmd_r;
    pend_full_next = pend_full_r;
    pend_data_next = pend_data_r;
    overrun_next   = overrun_r;
    mem_req_next   = mem_req_r;
    mem_we_next    = mem_we_r;
    mem_addr_next  = mem_addr_r;
    mem_wdata_next = mem_wdata_r;
    tx_start_next  = 1'b0;
    tx_fdata_next  = tx_fdata_r;
`ifdef CMD_TIMEOUT_EN
    tmo_cnt_next   = {TW{1'b0}};
`endif

    case (state_r)
      ST_IDLE: begin
        if (pend_full_r) begin
          // The buffered frame goes first. A frame arriving now refills the slot.
          cmd_next   = pend_data_r;
          state_next = ST_DECODE;
          if (iRX_DONE) begin
            pend_data_next = iRX_FDATA;
          end else begin
            pend_full_next = 1'b0;
          end
        end else if (iRX_DONE) begin
          cmd_next   = iRX_FDATA;
          state_next = ST_DECODE;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_DECODE: begin
        if (is_mem_op_s) begin
          mem_req_next   = 1'b1;
          mem_we_next    = (opc_s == OPC_WRITE);
          mem_addr_next  = addr_s;
          mem_wdata_next = data_s;
          state_next     = ST_MEM;
        end else if (is_legal_s) begin
          tx_start_next = 1'b1;
          tx_fdata_next = {opc_s | RESP_OK, addr_s, data_s};
          state_next    = ST_RESP;
        end else begin
          tx_start_next = 1'b1;
          tx_fdata_next = {RESP_ERR, addr_s, ERR_ILLEGAL};
          state_next    = ST_RESP;
        end
      end

      ST_MEM: begin
        if (iMEM_ACK) begin
          // A write echoes its data. A read returns the memory word.
          mem_req_next  = 1'b0;
          tx_start_next = 1'b1;
          tx_fdata_next = {opc_s | RESP_OK, addr_s, mem_we_r ? mem_wdata_r : iMEM_RDATA};
          state_next    = ST_RESP;
`ifdef CMD_TIMEOUT_EN
        end else if (tmo_hit_s) begin
          mem_req_next  = 1'b0;
          tx_start_next = 1'b1;
          tx_fdata_next = {RESP_ERR, addr_s, ERR_TIMEOUT};
          state_next    = ST_RESP;
        end else begin
          tmo_cnt_next = tmo_cnt_r + TW'(1);
          state_next   = ST_MEM;
        end
`else
        end else begin
          state_next = ST_MEM;
        end
`endif
      end

      ST_RESP: begin
        state_next = ST_WAIT_TX;
      end

      ST_WAIT_TX: begin
        if (iTX_DONE) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_WAIT_TX;
        end
      end

      default: begin
        state_next   = ST_IDLE;
        mem_req_next = 1'b0;
      end
    endcase

    // A frame arriving mid-command is buffered, or dropped if the slot is taken.
    if (iRX_DONE && (state_r != ST_IDLE)) begin
      if (!pend_full_r) begin
        pend_full_next = 1'b1;
        pend_data_next = iRX_FDATA;
      end else begin
        overrun_next = 1'b1;
      end
    end else begin
      overrun_next = overrun_next;
    end
  end

  // State and output registers. Reset abandons any command in flight.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      state_r     <= ST_IDLE;
      cmd_r       <= {FW{1'b0}};
      pend_full_r <= 1'b0;
      pend_data_r <= {FW{1'b0}};
      overrun_r   <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      tx_start_r  <= 1'b0;
      tx_fdata_r  <= {FW{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next;
      cmd_r       <= cmd_next;
      pend_full_r <= pend_full_next;
      pend_data_r <= pend_data_next;
      overrun_r   <= overrun_next;
      mem_req_r   <= mem_req_next;
      mem_we_r    <= mem_we_next;
      mem_addr_r  <= mem_addr_next;
      mem_wdata_r <= mem_wdata_next;
      tx_start_r  <= tx_start_next;
      tx_fdata_r  <= tx_fdata_next;
      busy_r      <= (state_next != ST_IDLE);
    end
  end

  assign oMEM_REQ   = mem_req_r;
  assign oMEM_WE    = mem_we_r;
  assign oMEM_ADDR  = mem_addr_r;
  assign oMEM_WDATA = mem_wdata_r;
  assign oTX_START  = tx_start_r;
  assign oTX_FDATA  = tx_fdata_r;
  assign oBUSY      = busy_r;
  assign oOVERRUN   = overrun_r;

endmodule
